// File: rtl/mem_stage_if.sv
// Request/response bundle between the EX/MEM register and the data-memory stage.
interface mem_stage_if;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [63:0] ADDR;
  logic [63:0] WRITE_DATA;
  logic [63:0] MEM_DATA;
  logic        STALL;
  logic        ERR;

  modport master (
    output MEM_READ, MEM_WRITE, ADDR, WRITE_DATA,
    input  MEM_DATA, STALL, ERR
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, ADDR, WRITE_DATA,
    output MEM_DATA, STALL, ERR
  );
endinterface

// File: rtl/mem_stage.sv
// Data-memory access stage: multi-cycle data RAM that stalls the pipeline until
// a legal load/store completes and drops illegal requests with a one-cycle ERR.
module mem_stage #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  mem_stage_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [63:0]   ram [DEPTH];

  logic          req;
  logic          legal;
  logic          complete;
  logic          do_write;
  logic [AW-1:0] idx;

  assign req   = bus.MEM_READ | bus.MEM_WRITE;
  assign idx   = bus.ADDR[3 +: AW];
  // DEPTH is a power of two, so "word index < DEPTH" is "no bits above the index".
  assign legal = (bus.MEM_READ ^ bus.MEM_WRITE)
              && (bus.ADDR[2:0] == 3'b000)
              && (bus.ADDR[63:3+AW] == '0);

  always_comb begin
    complete = 1'b0;
    if (!RESET && legal) begin
      if (state == IDLE) complete = (LATENCY == 1);
      else               complete = (cnt == LAST);
    end
  end

  assign do_write = complete & bus.MEM_WRITE;

  always_ff @(posedge CLK) begin
    if (do_write) ram[idx] <= bus.WRITE_DATA;
  end

  always_comb begin
    bus.STALL    = 1'b0;
    bus.ERR      = 1'b0;
    bus.MEM_DATA = '0;
    if (!RESET) begin
      bus.STALL = legal & ~complete;
      bus.ERR   = req & ~legal;
      if (complete && bus.MEM_READ) bus.MEM_DATA = ram[idx];
    end
  end

  // A request that turns illegal mid-access abandons it rather than hanging in BUSY.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (legal && LATENCY > 1) begin
        state <= BUSY;
        cnt   <= CW'(1);
      end
    end else begin
      if (!legal || cnt == LAST) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: four instances (LATENCY 1..4) checked every cycle against
// a transaction-level model, plus literal load expectations.
module tb_mem_stage;
  localparam int unsigned D = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [4];
  logic        rd  [4];
  logic        wr  [4];
  logic [63:0] addr[4];
  logic [63:0] wd  [4];
  logic        st  [4];
  logic        er  [4];
  logic [63:0] md  [4];

  mem_stage_if b0();
  mem_stage_if b1();
  mem_stage_if b2();
  mem_stage_if b3();

  assign b0.MEM_READ = rd[0]; assign b0.MEM_WRITE = wr[0];
  assign b0.ADDR = addr[0];   assign b0.WRITE_DATA = wd[0];
  assign st[0] = b0.STALL;    assign er[0] = b0.ERR;     assign md[0] = b0.MEM_DATA;
  assign b1.MEM_READ = rd[1]; assign b1.MEM_WRITE = wr[1];
  assign b1.ADDR = addr[1];   assign b1.WRITE_DATA = wd[1];
  assign st[1] = b1.STALL;    assign er[1] = b1.ERR;     assign md[1] = b1.MEM_DATA;
  assign b2.MEM_READ = rd[2]; assign b2.MEM_WRITE = wr[2];
  assign b2.ADDR = addr[2];   assign b2.WRITE_DATA = wd[2];
  assign st[2] = b2.STALL;    assign er[2] = b2.ERR;     assign md[2] = b2.MEM_DATA;
  assign b3.MEM_READ = rd[3]; assign b3.MEM_WRITE = wr[3];
  assign b3.ADDR = addr[3];   assign b3.WRITE_DATA = wd[3];
  assign st[3] = b3.STALL;    assign er[3] = b3.ERR;     assign md[3] = b3.MEM_DATA;

  mem_stage #(.DEPTH(D), .LATENCY(1)) u0 (.CLK(clk), .RESET(rst[0]), .bus(b0));
  mem_stage #(.DEPTH(D), .LATENCY(2)) u1 (.CLK(clk), .RESET(rst[1]), .bus(b1));
  mem_stage #(.DEPTH(D), .LATENCY(3)) u2 (.CLK(clk), .RESET(rst[2]), .bus(b2));
  mem_stage #(.DEPTH(D), .LATENCY(4)) u3 (.CLK(clk), .RESET(rst[3]), .bus(b3));

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mm [4][D];
  int          ph [4];
  logic [63:0] lit_exp [4];
  int          lit_tag [4];
  int          lit_seen[4];

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat%0d @%0t: got %h expected %h", nm, d + 1, $time, act, exp);
    end
  endtask

  // Model: a legal request occupies LATENCY consecutive cycles; only the last one completes.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      logic [63:0] e_data;
      logic        e_st, e_er, rq, lg, done;
      int          lat, w;
      lat = d + 1;
      e_data = '0; e_st = 1'b0; e_er = 1'b0;
      if (rst[d]) begin
        ph[d] = 0;
      end else begin
        rq = rd[d] | wr[d];
        lg = (rd[d] ^ wr[d]) && (addr[d] % 8 == 0) && (addr[d] < 64'(D * 8));
        if (!rq) begin
          ph[d] = 0;
        end else if (!lg) begin
          e_er  = 1'b1;
          ph[d] = 0;
        end else begin
          w    = int'(addr[d] / 8);
          done = (ph[d] == lat - 1);
          e_st = !done;
          if (done) begin
            if (rd[d]) begin
              e_data = mm[d][w];
              if (lit_tag[d] != lit_seen[d]) begin
                chk("lit_model", d, e_data, lit_exp[d]);
                chk("lit_dut", d, md[d], lit_exp[d]);
                lit_seen[d] = lit_tag[d];
              end
            end else begin
              mm[d][w] = wd[d];
            end
            ph[d] = 0;
          end else begin
            ph[d] = ph[d] + 1;
          end
        end
      end
      chk("stall", d, 64'(st[d]), 64'(e_st));
      chk("err", d, 64'(er[d]), 64'(e_er));
      chk("mem_data", d, md[d], e_data);
    end
  end

  task automatic go(input int d, input logic r, input logic w, input logic [63:0] a, input logic [63:0] v);
    rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = v;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!st[d]) break;
    end
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic ld_lit(input int d, input logic [63:0] a, input logic [63:0] exp);
    lit_exp[d] = exp;
    lit_tag[d] = lit_tag[d] + 1;
    go(d, 1'b1, 1'b0, a, {$urandom, $urandom});
  endtask

  task automatic idle(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      rd[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = {$urandom, $urandom};
      wd[d]   = {$urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 500000", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] v;
    int          c, w;
    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 64'h18; wd[d] = '1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) rst[d] = 1'b0;

    for (int d = 0; d < 4; d++)
      for (int i = 0; i < int'(D); i++)
        go(d, 1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom});

    go(1, 1'b0, 1'b1, 64'h0,  64'h0123_4567_89AB_CDEF);
    go(1, 1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
    go(1, 1'b1, 1'b1, 64'h10, 64'h3);
    go(1, 1'b0, 1'b1, 64'h13, 64'h1);
    go(1, 1'b0, 1'b1, 64'(D * 8), 64'h2);
    ld_lit(1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
    ld_lit(1, 64'h0,  64'h0123_4567_89AB_CDEF);

    go(3, 1'b0, 1'b1, 64'h0, 64'hAAAA_0000_1111_2222);
    go(3, 1'b0, 1'b1, 64'h8, 64'hBBBB_3333_4444_5555);
    idle(3, 1);
    ld_lit(3, 64'h0, 64'hAAAA_0000_1111_2222);
    ld_lit(3, 64'h8, 64'hBBBB_3333_4444_5555);

    go(0, 1'b0, 1'b1, 64'h8, 64'h5555_AAAA_0000_FFFF);
    ld_lit(0, 64'h8, 64'h5555_AAAA_0000_FFFF);
    for (int i = 0; i < 4; i++) begin
      v = {$urandom, $urandom};
      go(0, 1'b0, 1'b1, 64'h8, v);
      ld_lit(0, 64'h8, v);
    end

    go(2, 1'b0, 1'b1, 64'h20, 64'h2222);
    rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 64'h20; wd[2] = 64'h1111;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr[2] = 1'b0; rst[2] = 1'b0;
    idle(2, 1);
    ld_lit(2, 64'h20, 64'h2222);

    for (int d = 0; d < 4; d++) idle(d, 10);

    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 40; i++) begin
        c = int'($urandom_range(0, 9));
        w = int'($urandom_range(0, D - 1));
        v = {$urandom, $urandom};
        case (c)
          0:       go(d, 1'($urandom_range(0, 1)), 1'b1, 64'(w * 8 + int'($urandom_range(1, 7))), v);
          1:       go(d, 1'b0, 1'b1, 64'(D * 8) + 64'(8 * $urandom_range(0, 1000)), v);
          2:       go(d, 1'b1, 1'b1, 64'(w * 8), v);
          3, 4, 5: go(d, 1'b0, 1'b1, 64'(w * 8), v);
          default: go(d, 1'b1, 1'b0, 64'(w * 8), v);
        endcase
        if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 3)));
      end
    end

    for (int d = 0; d < 4; d++) idle(d, 2);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
